// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetch_pkg;

   localparam int OPC_W = 5;

   typedef enum logic [1:0] {
      ISSUE,
      WAIT,
      DROP
   } fetch_state_e;

   // Top OPC_W bits of an instruction word of width instr_w, zero-extended into 'word'.
   function automatic logic [OPC_W-1:0] opc_field(input logic [63:0] word, input int instr_w);
      logic [5:0] msb;
      msb = 6'(instr_w - 1);
      return word[msb -: OPC_W];
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, redirect and decoder-side outputs.
interface instr_fetch_if
   import fetch_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 16
);
   logic               imemReq;
   logic [ADDR_W-1:0]  imemAddr;
   logic               imemValid;
   logic [INSTR_W-1:0] imemData;
   logic               redirect;
   logic [ADDR_W-1:0]  redirectPc;
   logic               stall;
   logic               ifValid;
   logic [INSTR_W-1:0] ifInstr;
   logic [ADDR_W-1:0]  ifPc;
   logic [OPC_W-1:0]   opCode;

   modport master (
      output imemReq, imemAddr, ifValid, ifInstr, ifPc, opCode,
      input  imemValid, imemData, redirect, redirectPc, stall
   );

   modport slave (
      input  imemReq, imemAddr, ifValid, ifInstr, ifPc, opCode,
      output imemValid, imemData, redirect, redirectPc, stall
   );
endinterface

// File: rtl/fetch_skid.sv
// One-entry holding buffer for a fetched {instr, pc} that arrived while the output was stalled.
module fetch_skid
   import fetch_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic               flush_i,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic [ADDR_W-1:0]  pc_i,
   output logic               full_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic [ADDR_W-1:0]  pc_o
);
   logic               full_q;
   logic [INSTR_W-1:0] instr_q;
   logic [ADDR_W-1:0]  pc_q;

   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         full_q <= 1'b0;
      end else if (push_i) begin
         full_q <= 1'b1;
      end else if (pop_i) begin
         full_q <= 1'b0;
      end
   end

   // Payload needs no reset: it is only observed while full_q is set.
   always_ff @(posedge clk) begin
      if (push_i) begin
         instr_q <= instr_i;
         pc_q    <= pc_i;
      end
   end

   assign full_o  = full_q;
   assign instr_o = instr_q;
   assign pc_o    = pc_q;
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, single-outstanding memory request FSM, output register and skid buffer.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int              ADDR_W   = 16,
   parameter int              INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic          clk,
   input  logic          reset,
   instr_fetch_if.master fetch_io
);
   fetch_state_e       state_q;
   logic [ADDR_W-1:0]  pc_q;
   logic [ADDR_W-1:0]  pc_d;
   logic               if_valid_q;
   logic [INSTR_W-1:0] if_instr_q;
   logic [ADDR_W-1:0]  if_pc_q;

   logic               skid_full;
   logic               skid_push;
   logic               skid_pop;
   logic [INSTR_W-1:0] skid_instr;
   logic [ADDR_W-1:0]  skid_pc;

   logic               xfer;
   logic               mem_rsp;
   logic               accept;
   logic               req;

   assign pc_d    = pc_q + ADDR_W'(1);
   assign xfer    = if_valid_q & ~fetch_io.stall;
   assign mem_rsp = (state_q == WAIT) & fetch_io.imemValid;
   assign accept  = ~if_valid_q | xfer;
   assign req     = ~reset & (state_q == ISSUE) & ~skid_full & ~fetch_io.redirect;

   // The skid is only ever filled from WAIT, and WAIT is never entered while it is full,
   // so a push and a pop can never coincide.
   assign skid_push = mem_rsp & ~fetch_io.redirect & ~accept;
   assign skid_pop  = xfer & skid_full & ~fetch_io.redirect;

   fetch_skid #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_skid (
      .clk     (clk),
      .reset   (reset),
      .push_i  (skid_push),
      .pop_i   (skid_pop),
      .flush_i (fetch_io.redirect),
      .instr_i (fetch_io.imemData),
      .pc_i    (pc_q),
      .full_o  (skid_full),
      .instr_o (skid_instr),
      .pc_o    (skid_pc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ISSUE;
         pc_q       <= RESET_PC;
         if_valid_q <= 1'b0;
         if_instr_q <= '0;
         if_pc_q    <= '0;
      end else if (fetch_io.redirect) begin
         pc_q       <= fetch_io.redirectPc;
         if_valid_q <= 1'b0;
         // A request still in flight must be absorbed before the target is fetched.
         if (state_q == ISSUE || fetch_io.imemValid) begin
            state_q <= ISSUE;
         end else begin
            state_q <= DROP;
         end
      end else begin
         case (state_q)
            ISSUE: if (req) state_q <= WAIT;
            WAIT: begin
               if (fetch_io.imemValid) begin
                  pc_q    <= pc_d;
                  state_q <= ISSUE;
               end
            end
            DROP:    if (fetch_io.imemValid) state_q <= ISSUE;
            default: state_q <= ISSUE;
         endcase

         if (mem_rsp && accept) begin
            if_valid_q <= 1'b1;
            if_instr_q <= fetch_io.imemData;
            if_pc_q    <= pc_q;
         end else if (xfer) begin
            if_valid_q <= skid_full;
            if (skid_full) begin
               if_instr_q <= skid_instr;
               if_pc_q    <= skid_pc;
            end
         end
      end
   end

   assign fetch_io.imemReq  = req;
   assign fetch_io.imemAddr = pc_q;
   assign fetch_io.ifValid  = if_valid_q;
   assign fetch_io.ifInstr  = if_instr_q;
   assign fetch_io.ifPc     = if_pc_q;
   assign fetch_io.opCode   = opc_field(64'(if_instr_q), INSTR_W);
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage: owns the program counter, issues one-at-a-time reads to instruction memory, and presents the fetched instruction plus its 5-bit opcode field to the main decoder. It absorbs variable memory latency and downstream stalls with a one-entry skid buffer. Taken branches, `j`, `jal` and `jr` are applied through a redirect port.

## Interface
Parameters:
- `ADDR_W`, 16: PC / instruction-memory word-address width.
- `INSTR_W`, 16: instruction width; opcode is `[INSTR_W-1 -: 5]`.
- `RESET_PC`, 0: PC value after reset.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `imemReq`  out  1  one-cycle read-request pulse.
- `imemAddr`  out  ADDR_W  word address; valid while `imemReq`=1.
- `imemValid`  in  1  read data valid; one pulse per request, ≥1 cycle after `imemReq`.
- `imemData`  in  INSTR_W  instruction word, sampled when `imemValid`=1.
- `redirect`  in  1  flush and restart fetch at `redirectPc`.
- `redirectPc`  in  ADDR_W  target address.
- `stall`  in  1  downstream cannot accept the instruction this cycle.
- `ifValid`  out  1  `ifInstr` / `ifPc` hold a live instruction.
- `ifInstr`  out  INSTR_W  fetched instruction.
- `ifPc`  out  ADDR_W  address of `ifInstr`.
- `opCode`  out  5  `ifInstr[INSTR_W-1 -: 5]`, combinational.

## Operation
- A transfer occurs in any cycle with `ifValid`=1 and `stall`=0.
- FSM has three states:
  - **ISSUE**: if the skid buffer is empty, pulse `imemReq` with `imemAddr`=`pc` and go to WAIT. Otherwise stay, with `imemReq`=0.
  - **WAIT**: on `imemValid`, write `{imemData, pc}` to the output register if it is empty or transferring this cycle; otherwise write it to the skid buffer. Then set `pc`←`pc+1` (wraps mod 2^ADDR_W) and go to ISSUE.
  - **DROP**: a request is outstanding but stale. On `imemValid`, discard the data and go to ISSUE.
- Redirect (highest priority; overrides `stall`):
  - Next cycle: `pc`←`redirectPc`, `ifValid`←0, skid buffer emptied.
  - From WAIT without `imemValid` → DROP.
  - From WAIT or DROP with `imemValid` in the same cycle → data discarded, go to ISSUE.
  - From ISSUE → stay in ISSUE; the same-cycle `imemReq` pulse is suppressed.
  - Redirect while already in DROP: the new target replaces `pc`; stay in DROP.
- Skid buffer drains into the output register on a transfer cycle.
- At most one outstanding request at any time.
- `imemValid` in ISSUE is a protocol error: ignored. The bench flags it.

## Timing
- Reset values: `imemReq`=0, `imemAddr`=RESET_PC, `ifValid`=0, `ifInstr`=0, `ifPc`=0, `pc`=RESET_PC, FSM=ISSUE, skid buffer empty.
- `reset` is honoured mid-request: the state is cleared and any later `imemValid` for the old request arrives in ISSUE and is ignored.
- First `imemReq` occurs in the first cycle after `reset` deasserts.
- With 1-cycle memory:
  - `imemReq` at cycle N, `imemValid` at N+1.
  - `ifValid`=1 from N+2; the next `imemReq` is also at N+2.
  - Peak throughput: 1 instruction per 2 cycles.
- Redirect at cycle R: `ifValid`=0 at R+1. The first `imemReq` to the target is at R+1 if in ISSUE; otherwise it is the cycle after the stale `imemValid`.
- `ifInstr`/`ifPc` hold stable while `ifValid`=1 and `stall`=1.

## Structure
- `fetch_pkg`:
  - state enum `{ISSUE, WAIT, DROP}`.
  - `OPC_W`=5.
  - opcode-field slice helper function.
- Sub-module `fetch_skid`: one-entry buffer of `{instr, pc}` with `push`, `pop`, `flush` and `full` signals. The top level holds the PC, FSM and output register.

## Test plan
- Reset with RESET_PC=0x0010, 1-cycle memory returning 0x4123 → `imemReq` at cycle 1 with addr 0x0010; `ifValid` at cycle 3 with `ifInstr`=0x4123, `ifPc`=0x0010, `opCode`=0b01000.
- Continuous fetch, no stall, 1-cycle memory → addresses 0x10, 0x11, 0x12 requested every 2 cycles; `ifPc` follows in order.
- `stall` held 6 cycles starting at `ifValid` → output frozen; the in-flight word lands in skid; no new `imemReq` while skid is full; after release, the two instructions transfer on consecutive cycles.
- Redirect to 0x0200 while in WAIT with 3-cycle memory latency → next cycle `ifValid`=0 and state DROP; stale data discarded; next `imemReq` addr 0x0200.
- Redirect and `imemValid` in the same cycle, with `stall`=1 → data discarded, output flushed, fetch resumes at the target.
- PC=0xFFFF with ADDR_W=16 → next request addr 0x0000.
